// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states, flag layout.
// ALU_DIV_EN selects whether DIV runs on the iterative datapath.
package alu_pkg;

    localparam int unsigned OP_W      = 4;
    localparam int unsigned NUM_FLAGS = 4;

    localparam logic [OP_W-1:0] OP_ADD = 4'd3;
    localparam logic [OP_W-1:0] OP_SUB = 4'd4;
    localparam logic [OP_W-1:0] OP_MUL = 4'd5;
    localparam logic [OP_W-1:0] OP_DIV = 4'd6;
    localparam logic [OP_W-1:0] OP_AND = 4'd7;
    localparam logic [OP_W-1:0] OP_OR  = 4'd8;
    localparam logic [OP_W-1:0] OP_XOR = 4'd9;
    localparam logic [OP_W-1:0] OP_SHL = 4'd10;
    localparam logic [OP_W-1:0] OP_SHR = 4'd11;

    localparam int unsigned FLAG_O = 3;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_Z = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_t;

    // Operations that run on the bit-serial datapath
    function automatic logic is_iter_op(input logic [OP_W-1:0] op);
`ifdef ALU_DIV_EN
        return (op == OP_MUL) || (op == OP_DIV);
`else
        return (op == OP_MUL);
`endif
    endfunction

    function automatic logic [NUM_FLAGS-1:0] pack_flags(input logic o, input logic c,
                                                        input logic n, input logic z);
        logic [NUM_FLAGS-1:0] f;
        f         = '0;
        f[FLAG_O] = o;
        f[FLAG_C] = c;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        return f;
    endfunction

endpackage

// File: rtl/alu_iter.sv
// Bit-serial unsigned multiplier (shift-add) and, with ALU_DIV_EN, restoring divider.
// One bit per cycle; done pulses after WIDTH steps. res_hi/res_lo = product or remainder/quotient.
module alu_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef ALU_DIV_EN
    input  logic             div_mode,
`endif
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             done,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic             running;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] hi_d;
    logic [WIDTH-1:0] lo_d;
`ifdef ALU_DIV_EN
    logic             div_q;
`endif

    // One iteration step: hi_q is partial product (MUL) or partial remainder (DIV)
    always_comb begin : step
        logic [WIDTH:0]   sum;
`ifdef ALU_DIV_EN
        logic [WIDTH:0]   shifted;
        logic [WIDTH-1:0] diff;
        shifted = '0;
        diff    = '0;
`endif
        sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        hi_d = sum[WIDTH:1];
        lo_d = {sum[0], lo_q[WIDTH-1:1]};
`ifdef ALU_DIV_EN
        if (div_q) begin
            shifted = {hi_q, lo_q[WIDTH-1]};
            // remainder stays below divisor, so the W-bit difference is exact when taken
            diff    = shifted[WIDTH-1:0] - b_q;
            if (shifted >= {1'b0, b_q}) begin
                hi_d = diff;
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = shifted[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running <= 1'b0;
            cnt     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            b_q     <= '0;
            done    <= 1'b0;
`ifdef ALU_DIV_EN
            div_q   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (start) begin
                running <= 1'b1;
                cnt     <= '0;
                hi_q    <= '0;
                lo_q    <= op_a;
                b_q     <= op_b;
`ifdef ALU_DIV_EN
                div_q   <= div_mode;
`endif
            end else if (running) begin
                hi_q <= hi_d;
                lo_q <= lo_d;
                cnt  <= cnt + CNT_W'(1);
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

    assign res_lo = lo_q;
    assign res_hi = hi_q;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: FSM control, single-cycle ops and flag generation around alu_iter.
// Define ALU_DIV_EN to enable the iterative divider; otherwise DIV reports unsupported.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [OP_W-1:0]      opcode,
    input  logic                 ar_flag,
    input  logic [WIDTH-1:0]     src1,
    input  logic [WIDTH-1:0]     src2,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     out,
    output logic [NUM_FLAGS-1:0] flags
);

    localparam int unsigned MSB = WIDTH - 1;

    state_t               state_q, state_d;
    logic [OP_W-1:0]      op_q, op_d;
    logic                 ar_q, ar_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [WIDTH-1:0]     res_q, res_d;
    logic [NUM_FLAGS-1:0] flg_q, flg_d;
    logic [WIDTH-1:0]     out_d;
    logic [NUM_FLAGS-1:0] flags_d;
    logic                 busy_d;
    logic                 done_d;

    logic                 iter_start_c;
    logic                 iter_done;
    logic [WIDTH-1:0]     iter_lo;
    logic [WIDTH-1:0]     iter_hi;
    logic [WIDTH-1:0]     exec_res_c;
    logic [NUM_FLAGS-1:0] exec_flags_c;
    logic [NUM_FLAGS-1:0] iter_flags_c;

    alu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .rst      (rst),
        .start    (iter_start_c),
`ifdef ALU_DIV_EN
        .div_mode (opcode == OP_DIV),
`endif
        .op_a     (src1),
        .op_b     (src2),
        .done     (iter_done),
        .res_lo   (iter_lo),
        .res_hi   (iter_hi)
    );

    // Single-cycle operations on the captured operands
    always_comb begin : exec_ops
        logic [WIDTH:0]  wide;
        logic [SHW-1:0]  sh_amt;
        int unsigned     rot;
        logic            c;
        logic            o;
        wide       = '0;
        rot        = 0;
        c          = 1'b0;
        o          = 1'b0;
        sh_amt     = b_q[SHW-1:0];
        exec_res_c = '0;
        case (op_q)
            OP_ADD: begin
                wide       = {1'b0, a_q} + {1'b0, b_q};
                exec_res_c = wide[WIDTH-1:0];
                c          = wide[WIDTH];
                o          = (a_q[MSB] == b_q[MSB]) && (exec_res_c[MSB] != a_q[MSB]);
            end
            OP_SUB: begin
                wide       = {1'b0, a_q} - {1'b0, b_q};
                exec_res_c = wide[WIDTH-1:0];
                c          = wide[WIDTH];
                o          = (a_q[MSB] != b_q[MSB]) && (exec_res_c[MSB] != a_q[MSB]);
            end
            OP_AND: exec_res_c = a_q & b_q;
            OP_OR:  exec_res_c = a_q | b_q;
            OP_XOR: exec_res_c = a_q ^ b_q;
            OP_SHL: begin
                if (ar_q) begin
                    rot        = 32'(sh_amt) % WIDTH;
                    exec_res_c = (a_q << rot) | (a_q >> (WIDTH - rot));
                    c          = (sh_amt != '0) && exec_res_c[0];
                end else begin
                    // extra top bit catches the last bit shifted out
                    wide       = {1'b0, a_q} << sh_amt;
                    exec_res_c = wide[WIDTH-1:0];
                    c          = wide[WIDTH];
                end
            end
            OP_SHR: begin
                if (ar_q) begin
                    wide = $signed({a_q, 1'b0}) >>> sh_amt;
                end else begin
                    wide = {a_q, 1'b0} >> sh_amt;
                end
                exec_res_c = wide[WIDTH:1];
                c          = wide[0];
            end
`ifndef ALU_DIV_EN
            OP_DIV: o = 1'b1;
`endif
            default: exec_res_c = '0;
        endcase
        exec_flags_c = pack_flags(o, c, exec_res_c[MSB], exec_res_c == '0);
    end

    // Flags for results coming off the iterative datapath
    always_comb begin : iter_flags
        logic ovf;
        logic cry;
        ovf = |iter_hi;
        cry = |iter_hi;
`ifdef ALU_DIV_EN
        if (op_q == OP_DIV) begin
            ovf = (b_q == '0);
            cry = 1'b0;
        end
`endif
        iter_flags_c = pack_flags(ovf, cry, iter_lo[MSB], iter_lo == '0);
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        ar_d         = ar_q;
        a_d          = a_q;
        b_d          = b_q;
        res_d        = res_q;
        flg_d        = flg_q;
        out_d        = out;
        flags_d      = flags;
        done_d       = 1'b0;
        iter_start_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !busy) begin
                    op_d         = opcode;
                    ar_d         = ar_flag;
                    a_d          = src1;
                    b_d          = src2;
                    iter_start_c = is_iter_op(opcode);
                    state_d      = is_iter_op(opcode) ? ITER : EXEC;
                end
            end
            EXEC: begin
                res_d   = exec_res_c;
                flg_d   = exec_flags_c;
                state_d = DONE;
            end
            ITER: begin
                if (iter_done) begin
                    res_d   = iter_lo;
                    flg_d   = iter_flags_c;
                    state_d = DONE;
                end
            end
            DONE: begin
                out_d   = res_q;
                flags_d = flg_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // busy also covers the done cycle, which is spent back in IDLE
        busy_d = (state_d != IDLE) || (state_q == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            ar_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            flg_q   <= '0;
            out     <= '0;
            flags   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ar_q    <= ar_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
            out     <= out_d;
            flags   <= flags_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=16 and WIDTH=32; honours ALU_DIV_EN.
`timescale 1ns/1ps
module tb_alu_seq;
    import alu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        s16, ar16, busy16, done16;
    logic [3:0]  op16, fl16;
    logic [15:0] a16, b16, out16;
    logic        s32, ar32, busy32, done32;
    logic [3:0]  op32, fl32;
    logic [31:0] a32, b32, out32;

    alu_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(s16), .opcode(op16), .ar_flag(ar16),
        .src1(a16), .src2(b16), .busy(busy16), .done(done16), .out(out16), .flags(fl16)
    );

    alu_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(s32), .opcode(op32), .ar_flag(ar32),
        .src1(a32), .src2(b32), .busy(busy32), .done(done32), .out(out32), .flags(fl32)
    );

    typedef struct {
        string      tag;
        logic [63:0] res;
        logic [3:0]  flg;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q16[$];
    exp_t q32[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    logic [3:0] rnd_ops [4] = '{OP_ADD, OP_SUB, OP_XOR, OP_MUL};

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Compare each done pulse against the oldest outstanding expectation
    always @(negedge clk) begin : mon16
        exp_t e;
        if (done16) begin
            if (q16.size() == 0) begin
                check("spurious_done16", 64'(done16), 64'd0);
            end else begin
                e = q16.pop_front();
                check({e.tag, "_out"},   64'(out16), e.res);
                check({e.tag, "_flags"}, 64'(fl16), 64'(e.flg));
                check({e.tag, "_lat"},   64'(cyc - e.acc), 64'(e.lat));
                check({e.tag, "_busy"},  64'(busy16), 64'd1);
            end
        end
    end

    always @(negedge clk) begin : mon32
        exp_t e;
        if (done32) begin
            if (q32.size() == 0) begin
                check("spurious_done32", 64'(done32), 64'd0);
            end else begin
                e = q32.pop_front();
                check({e.tag, "_out"},   64'(out32), e.res);
                check({e.tag, "_flags"}, 64'(fl32), 64'(e.flg));
                check({e.tag, "_lat"},   64'(cyc - e.acc), 64'(e.lat));
            end
        end
    end

    // Drive one request; start stays high for 'hold' edges (extra edges must be ignored)
    task automatic issue(input int sel, input string tag, input logic [3:0] op, input logic ar,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] eres, input logic [3:0] eflg, input int lat,
                         input int hold);
        exp_t e;
        @(negedge clk);
        e.tag = tag; e.res = eres; e.flg = eflg; e.lat = lat; e.acc = cyc + 1;
        if (sel == 16) begin
            op16 = op; ar16 = ar; a16 = a[15:0]; b16 = b[15:0]; s16 = 1'b1;
            q16.push_back(e);
        end else begin
            op32 = op; ar32 = ar; a32 = a[31:0]; b32 = b[31:0]; s32 = 1'b1;
            q32.push_back(e);
        end
        repeat (hold) @(negedge clk);
        s16 = 1'b0; s32 = 1'b0;
        op16 = 4'($urandom); ar16 = 1'($urandom); a16 = 16'($urandom); b16 = 16'($urandom);
        op32 = 4'($urandom); ar32 = 1'($urandom); a32 = $urandom;       b32 = $urandom;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((q16.size() != 0 || q32.size() != 0 || busy16 || busy32) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drain"}, 64'(q16.size() + q32.size()), 64'd0);
    endtask

    function automatic void model16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                    output logic [15:0] r, output logic [3:0] f, output int lat);
        logic [31:0] p;
        logic        c, o;
        c = 1'b0; o = 1'b0; lat = 2; r = '0; p = '0;
        case (op)
            OP_ADD: begin {c, r} = {1'b0, a} + {1'b0, b}; o = (a[15] == b[15]) && (r[15] != a[15]); end
            OP_SUB: begin r = a - b; c = (a < b); o = (a[15] != b[15]) && (r[15] != a[15]); end
            OP_XOR: r = a ^ b;
            OP_MUL: begin p = a * b; r = p[15:0]; c = (p[31:16] != 0); o = c; lat = 18; end
            default: r = '0;
        endcase
        f = {o, c, r[15], r == 16'd0};
    endfunction

    initial begin : main
        logic [15:0] ra, rb, rr;
        logic [3:0]  rf;
        logic [3:0]  rop;
        int          rl;
        rst = 1'b1;
        s16 = 0; ar16 = 0; op16 = 0; a16 = 0; b16 = 0;
        s32 = 0; ar32 = 0; op32 = 0; a32 = 0; b32 = 0;
        repeat (3) @(negedge clk);
        check("rst_out16",   64'(out16), 64'd0);
        check("rst_flags16", 64'(fl16), 64'd0);
        check("rst_busy16",  64'(busy16), 64'd0);
        check("rst_done16",  64'(done16), 64'd0);
        check("rst_out32",   64'(out32), 64'd0);
        check("rst_busy32",  64'(busy32), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        issue(16, "add_ovf", OP_ADD, 0, 'h7FFF, 'h0001, 'h8000, 4'b1010, 2, 4);
        wait_idle("add_ovf");
        issue(16, "sub_borrow", OP_SUB, 0, 'h0000, 'h0001, 'hFFFF, 4'b0110, 2, 1);
        wait_idle("sub_borrow");
        issue(16, "and_zero", OP_AND, 0, 'h00F0, 'h0F00, 'h0000, 4'b0001, 2, 1);
        wait_idle("and_zero");
        issue(16, "or", OP_OR, 0, 'h8001, 'h0100, 'h8101, 4'b0010, 2, 1);
        wait_idle("or");
        issue(16, "nop0", 4'd0, 0, 'h1234, 'h5678, 'h0000, 4'b0001, 2, 1);
        wait_idle("nop0");
        issue(16, "nop15", 4'd15, 1, 'hFFFF, 'hFFFF, 'h0000, 4'b0001, 2, 1);
        wait_idle("nop15");
        issue(16, "mul_hi", OP_MUL, 0, 'h0100, 'h0100, 'h0000, 4'b1101, 18, 6);
        wait_idle("mul_hi");
        issue(16, "shl_amt_mask", OP_SHL, 0, 'h0001, 'hFFF3, 'h0008, 4'b0000, 2, 1);
        wait_idle("shl_amt_mask");
        issue(16, "shr_log", OP_SHR, 0, 'h8001, 'h0001, 'h4000, 4'b0100, 2, 1);
        wait_idle("shr_log");
        issue(16, "shr_zero_amt", OP_SHR, 1, 'h8001, 'h0000, 'h8001, 4'b0010, 2, 1);
        wait_idle("shr_zero_amt");
        issue(16, "shl_15", OP_SHL, 0, 'h0003, 'h000F, 'h8000, 4'b0110, 2, 1);
        wait_idle("shl_15");
        repeat (3) @(negedge clk);
        check("hold_out16",   64'(out16), 64'h8000);
        check("hold_flags16", 64'(fl16), 64'h6);

`ifdef ALU_DIV_EN
        issue(16, "div", OP_DIV, 0, 100, 7, 14, 4'b0000, 18, 1);
        wait_idle("div");
        issue(16, "div_by0", OP_DIV, 0, 5, 0, 'hFFFF, 4'b1010, 18, 3);
        wait_idle("div_by0");
`else
        issue(16, "div_unsup", OP_DIV, 0, 100, 7, 0, 4'b1001, 2, 1);
        wait_idle("div_unsup");
`endif

        for (int i = 0; i < 8; i++) begin
            rop = rnd_ops[i % 4];
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            model16(rop, ra, rb, rr, rf, rl);
            issue(16, $sformatf("rnd%0d", i), rop, 0, 64'(ra), 64'(rb), 64'(rr), rf, rl, 1);
            wait_idle("rnd");
        end

        issue(32, "shr_arith32", OP_SHR, 1, 'h80000001, 1, 'hC0000000, 4'b0110, 2, 1);
        wait_idle("shr_arith32");
        issue(32, "rotl32", OP_SHL, 1, 'h80000000, 1, 'h00000001, 4'b0100, 2, 1);
        wait_idle("rotl32");
        issue(32, "mul32", OP_MUL, 0, 'hFFFFFFFF, 2, 'hFFFFFFFE, 4'b1110, 34, 1);
        wait_idle("mul32");

        // Abort a MUL in flight; its expectation is withdrawn
        issue(16, "mul_abort", OP_MUL, 0, 'h0003, 'h0005, 'h000F, 4'b0000, 18, 1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        q16.delete();
        #1;
        check("abort_busy16",  64'(busy16), 64'd0);
        check("abort_out16",   64'(out16), 64'd0);
        check("abort_flags16", 64'(fl16), 64'd0);
        check("abort_done16",  64'(done16), 64'd0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (24) @(negedge clk);
        check("post_rst_busy16", 64'(busy16), 64'd0);
        issue(16, "add_after_rst", OP_ADD, 0, 2, 3, 5, 4'b0000, 2, 1);
        wait_idle("add_after_rst");

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
